// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default geometry,
// soft-clear state encoding and the byte-lane merge helper.
package regfile_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;

    // Widest register the merge helper supports; narrower callers zero-extend.
    localparam int MAX_DATA_W = 256;
    localparam int MAX_BYTES  = MAX_DATA_W / 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    function automatic logic [MAX_DATA_W-1:0] merge_be(
        input logic [MAX_DATA_W-1:0] old_val,
        input logic [MAX_DATA_W-1:0] new_val,
        input logic [MAX_BYTES-1:0]  be
    );
        logic [MAX_DATA_W-1:0] res;
        for (int b = 0; b < MAX_BYTES; b++) begin
            res[b*8 +: 8] = be[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle between decode/writeback (master) and the register file (slave).
interface regfile_mp_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int NUM_RD = 3,
    parameter int NUM_WR = 2
);
    logic [NUM_WR-1:0]          W_En;
    logic [NUM_WR*ADDR_W-1:0]   W_Addr;
    logic [NUM_WR*DATA_W-1:0]   W_Data;
    logic [NUM_WR*DATA_W/8-1:0] W_Be;
    logic [NUM_RD*ADDR_W-1:0]   R_Addr;
    logic [NUM_RD*DATA_W-1:0]   R_Data;
    logic                       Clr_Req;
    logic                       Clr_Busy;

    modport master (
        output W_En, W_Addr, W_Data, W_Be, R_Addr, Clr_Req,
        input  R_Data, Clr_Busy
    );

    modport slave (
        input  W_En, W_Addr, W_Data, W_Be, R_Addr, Clr_Req,
        output R_Data, Clr_Busy
    );
endinterface

// File: rtl/regfile_clr_seq.sv
// Soft-clear sequencer: walks every register address once, one per cycle.
//   state    | meaning
//   ST_IDLE  | waiting for Clr_Req; register file fully usable
//   ST_CLEAR | zeroing reg[cnt]; writes, bypass and further requests ignored
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Clr_Req,
    output logic              Clr_Busy,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              clr_we
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    clr_state_t        state;
    logic [ADDR_W-1:0] cnt;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            Clr_Busy <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Clr_Req) begin
                        state    <= ST_CLEAR;
                        cnt      <= '0;
                        Clr_Busy <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    // Reaching the last address is the exit; the counter never wraps.
                    if (cnt == LAST_ADDR) begin
                        state    <= ST_IDLE;
                        cnt      <= '0;
                        Clr_Busy <= 1'b0;
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    cnt      <= '0;
                    Clr_Busy <= 1'b0;
                end
            endcase
        end
    end

    assign clr_addr = cnt;
    assign clr_we   = (state == ST_CLEAR);

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: async reads with optional write bypass, byte-enabled
// clocked writes, optional hardwired zero register and a sequenced soft clear.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_RD   = 3,
    parameter int NUM_WR   = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input logic         Clk,
    input logic         Rst_n,
    regfile_mp_if.slave bus
);

    localparam int NUMB   = 2 ** ADDR_W;
    localparam int BYTE_W = DATA_W / 8;

    function automatic logic [DATA_W-1:0] merge_w(
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] new_val,
        input logic [BYTE_W-1:0] be
    );
        return DATA_W'(merge_be(MAX_DATA_W'(old_val), MAX_DATA_W'(new_val), MAX_BYTES'(be)));
    endfunction

    logic [DATA_W-1:0] mem     [NUMB];
    logic [DATA_W-1:0] mem_nxt [NUMB];

    logic [ADDR_W-1:0] waddr [NUM_WR];
    logic [DATA_W-1:0] wdata [NUM_WR];
    logic [BYTE_W-1:0] wbe   [NUM_WR];
    logic [NUM_WR-1:0] wr_act;

    logic [ADDR_W-1:0] raddr  [NUM_RD];
    logic [DATA_W-1:0] rd_val [NUM_RD];

    logic              clr_busy;
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_we;

    regfile_clr_seq #(
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Clr_Req  (bus.Clr_Req),
        .Clr_Busy (clr_busy),
        .clr_addr (clr_addr),
        .clr_we   (clr_we)
    );

    assign bus.Clr_Busy = clr_busy;

    for (genvar p = 0; p < NUM_WR; p++) begin : g_wr_unpack
        assign waddr[p]  = bus.W_Addr[p*ADDR_W +: ADDR_W];
        assign wdata[p]  = bus.W_Data[p*DATA_W +: DATA_W];
        assign wbe[p]    = bus.W_Be[p*BYTE_W +: BYTE_W];
        assign wr_act[p] = bus.W_En[p] & ~clr_we;
    end

    // Ports are folded in ascending order so the highest port wins per byte.
    always_comb begin
        for (int i = 0; i < NUMB; i++) begin
            mem_nxt[i] = mem[i];
        end
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_act[p]) begin
                mem_nxt[waddr[p]] = merge_w(mem_nxt[waddr[p]], wdata[p], wbe[p]);
            end
        end
        if (clr_we) begin
            mem_nxt[clr_addr] = '0;
        end
        if (ZERO_REG) begin
            mem_nxt[0] = '0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < NUMB; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUMB; i++) begin
                mem[i] <= mem_nxt[i];
            end
        end
    end

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        assign raddr[r] = bus.R_Addr[r*ADDR_W +: ADDR_W];

        always_comb begin
            rd_val[r] = mem[raddr[r]];
            if (BYPASS && !clr_we) begin
                for (int p = 0; p < NUM_WR; p++) begin
                    if (wr_act[p] && (waddr[p] == raddr[r])) begin
                        rd_val[r] = merge_w(rd_val[r], wdata[p], wbe[p]);
                    end
                end
            end
            if (ZERO_REG && (raddr[r] == '0)) begin
                rd_val[r] = '0;
            end
        end

        assign bus.R_Data[r*DATA_W +: DATA_W] = rd_val[r];
    end

endmodule
